// File: rtl/controller_pkg.sv
// controller_pkg: shared CCC sequencer types and the I3C broadcast address
package controller_pkg;

  localparam logic [6:0] I3C_BCAST_ADDR = 7'h7E;

  typedef enum logic [2:0] {
    OP_START  = 3'd0,
    OP_RSTART = 3'd1,
    OP_WRITE  = 3'd2,
    OP_READ   = 3'd3,
    OP_STOP   = 3'd4
  } ccc_bus_op_e;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_NACK_BCAST = 2'd1,
    ERR_NACK_ADDR  = 2'd2
  } ccc_err_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_BADDR,
    S_CODE,
    S_DB,
    S_BDATA,
    S_RSTART,
    S_DADDR,
    S_DWR,
    S_DRD,
    S_STOP,
    S_RESP
  } ccc_state_e;

endpackage

// File: rtl/ccc_initiator.sv
// ccc_initiator: sequences one CCC request into SDR bus primitives and collects the response
module ccc_initiator
  import controller_pkg::*;
#(
  parameter int MaxDataBytes = 4,
  localparam int LW = $clog2(MaxDataBytes + 1),
  localparam int IW = (MaxDataBytes > 1) ? $clog2(MaxDataBytes) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [7:0]                req_code_i,
  input  logic                      req_db_valid_i,
  input  logic [7:0]                req_db_i,
  input  logic [6:0]                req_addr_i,
  input  logic                      req_rnw_i,
  input  logic [LW-1:0]             req_len_i,
  input  logic [8*MaxDataBytes-1:0] req_data_i,
  output logic                      bus_req_o,
  output ccc_bus_op_e               bus_op_o,
  output logic [7:0]                bus_byte_o,
  output logic                      bus_last_o,
  input  logic                      bus_done_i,
  input  logic                      bus_nack_i,
  input  logic [7:0]                bus_rdata_i,
  output logic                      rsp_valid_o,
  output ccc_err_e                  rsp_err_o,
  output logic [LW-1:0]             rsp_len_o,
  output logic [8*MaxDataBytes-1:0] rsp_data_o
);

  ccc_state_e state_q, state_d, adv, after_cmd;
  logic [7:0] code_q, db_q;
  logic db_v_q, rnw_q;
  logic [6:0] addr_q;
  logic [LW-1:0] len_q;
  logic [8*MaxDataBytes-1:0] data_q;
  logic [IW-1:0] idx_q;
  logic gap_q, accept, fire, last, bus_state;

  assign req_ready_o = state_q == S_IDLE;
  assign rsp_valid_o = state_q == S_RESP;
  assign accept      = req_valid_i && req_ready_o;
  assign bus_state   = !(state_q == S_IDLE || state_q == S_RESP);
  // gap_q forces one idle cycle after each completion so a done pulse is never reused
  assign bus_req_o   = bus_state && !gap_q;
  assign fire        = bus_req_o && bus_done_i;
  assign last        = LW'(idx_q) == len_q - LW'(1);
  assign bus_last_o  = state_q == S_DRD && last;

  always_comb begin
    after_cmd = code_q[7] ? S_RSTART : (len_q != '0 ? S_BDATA : S_STOP);
    adv = state_q;
    case (state_q)
      S_START:              adv = S_BADDR;
      S_BADDR:              adv = bus_nack_i ? S_STOP : S_CODE;
      S_CODE:               adv = db_v_q ? S_DB : after_cmd;
      S_DB:                 adv = after_cmd;
      S_BDATA, S_DWR, S_DRD: adv = last ? S_STOP : state_q;
      S_RSTART:             adv = S_DADDR;
      S_DADDR:              adv = (bus_nack_i || len_q == '0) ? S_STOP : (rnw_q ? S_DRD : S_DWR);
      S_STOP:               adv = S_RESP;
      default:              adv = state_q;
    endcase
    state_d = state_q == S_IDLE ? (accept ? S_START : S_IDLE) :
              state_q == S_RESP ? S_IDLE : fire ? adv : state_q;
  end

  always_comb begin
    bus_op_o = state_q == S_START  ? OP_START  :
               state_q == S_RSTART ? OP_RSTART :
               state_q == S_STOP   ? OP_STOP   :
               state_q == S_DRD    ? OP_READ   :
               bus_state           ? OP_WRITE  : OP_START;
    case (state_q)
      S_BADDR:      bus_byte_o = {I3C_BCAST_ADDR, 1'b0};
      S_CODE:       bus_byte_o = code_q;
      S_DB:         bus_byte_o = db_q;
      S_DADDR:      bus_byte_o = {addr_q, rnw_q};
      S_BDATA, S_DWR: bus_byte_o = data_q[{idx_q, 3'b000} +: 8];
      default:      bus_byte_o = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gap_q      <= 1'b0;
      idx_q      <= '0;
      code_q     <= '0;
      db_q       <= '0;
      db_v_q     <= 1'b0;
      addr_q     <= '0;
      rnw_q      <= 1'b0;
      len_q      <= '0;
      data_q     <= '0;
      rsp_err_o  <= ERR_NONE;
      rsp_len_o  <= '0;
      rsp_data_o <= '0;
    end else begin
      gap_q <= fire;
      idx_q <= (state_d != state_q) ? '0 : fire ? idx_q + IW'(1) : idx_q;
      if (accept) begin
        code_q     <= req_code_i;
        db_q       <= req_db_i;
        db_v_q     <= req_db_valid_i;
        addr_q     <= req_addr_i;
        rnw_q      <= req_rnw_i;
        len_q      <= (req_len_i > LW'(MaxDataBytes)) ? LW'(MaxDataBytes) : req_len_i;
        data_q     <= req_data_i;
        rsp_err_o  <= ERR_NONE;
        rsp_len_o  <= '0;
        rsp_data_o <= '0;
      end
      if (fire && bus_nack_i && state_q == S_BADDR) rsp_err_o <= ERR_NACK_BCAST;
      if (fire && bus_nack_i && state_q == S_DADDR) begin
        rsp_err_o <= ERR_NACK_ADDR;
        rsp_len_o <= '0;
      end
      if (fire && state_q == S_DRD) begin
        rsp_data_o[{idx_q, 3'b000} +: 8] <= bus_rdata_i;
        rsp_len_o <= rsp_len_o + LW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ccc_initiator.sv
// tb_ccc_initiator: scoreboard bench with a bus responder model and directed CCC transactions
module tb_ccc_initiator;
  import controller_pkg::*;

  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic req_valid_i, req_ready_o, req_db_valid_i, req_rnw_i;
  logic [7:0] req_code_i, req_db_i;
  logic [6:0] req_addr_i;
  logic [2:0] req_len_i, rsp_len_o;
  logic [31:0] req_data_i, rsp_data_o;
  logic bus_req_o, bus_last_o, bus_done_i, bus_nack_i, rsp_valid_o;
  ccc_bus_op_e bus_op_o;
  logic [7:0] bus_byte_o, bus_rdata_i;
  ccc_err_e rsp_err_o;

  ccc_initiator #(.MaxDataBytes(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_code_i(req_code_i), .req_db_valid_i(req_db_valid_i), .req_db_i(req_db_i),
    .req_addr_i(req_addr_i), .req_rnw_i(req_rnw_i), .req_len_i(req_len_i), .req_data_i(req_data_i),
    .bus_req_o(bus_req_o), .bus_op_o(bus_op_o), .bus_byte_o(bus_byte_o), .bus_last_o(bus_last_o),
    .bus_done_i(bus_done_i), .bus_nack_i(bus_nack_i), .bus_rdata_i(bus_rdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_err_o(rsp_err_o), .rsp_len_o(rsp_len_o), .rsp_data_o(rsp_data_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {ccc_bus_op_e op; logic [7:0] b; logic last;} op_t;
  typedef struct {ccc_err_e err; logic [2:0] len; logic [31:0] data;} rsp_t;
  op_t exp_ops[$];
  rsp_t exp_rsp[$];
  logic [7:0] rd_q[$];
  int n_chk = 0, n_pass = 0, rsp_seen = 0;
  logic nack_en = 1'b0;
  logic [7:0] nack_byte = 8'h00;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic ex(ccc_bus_op_e op, logic [7:0] b = 8'h00, logic l = 1'b0);
    exp_ops.push_back('{op, b, l});
  endtask

  task automatic er(ccc_err_e e, logic [2:0] l, logic [31:0] d);
    exp_rsp.push_back('{e, l, d});
  endtask

  // bus layer model: one cycle of request, then a done pulse with programmed nack/rdata
  initial begin
    bus_done_i = 1'b0; bus_nack_i = 1'b0; bus_rdata_i = 8'h00;
    forever begin
      @(posedge clk_i); #2;
      if (bus_req_o) begin
        bus_nack_i = nack_en && bus_op_o == OP_WRITE && bus_byte_o == nack_byte;
        bus_rdata_i = 8'h00;
        if (bus_op_o == OP_READ && rd_q.size() > 0) bus_rdata_i = rd_q.pop_front();
        bus_done_i = 1'b1;
        @(posedge clk_i); #2;
        bus_done_i = 1'b0;
        bus_nack_i = 1'b0;
      end
    end
  end

  always @(negedge clk_i) begin : monitor
    op_t e;
    rsp_t r;
    if (rst_ni && bus_req_o && bus_done_i) begin
      if (exp_ops.size() == 0) begin
        n_chk++;
        $display("FAIL op_extra: got op %0d byte %h expected no primitive", bus_op_o, bus_byte_o);
      end else begin
        e = exp_ops.pop_front();
        chk("bus_op", bus_op_o, e.op);
        if (e.op == OP_WRITE) chk("bus_byte", bus_byte_o, e.b);
        if (e.op == OP_READ) chk("bus_last", bus_last_o, e.last);
      end
    end
    if (rst_ni && rsp_valid_o) begin
      rsp_seen++;
      chk("ready_during_rsp", req_ready_o, 0);
      if (exp_rsp.size() == 0) begin
        n_chk++;
        $display("FAIL rsp_extra: got err %0d len %0d expected no response", rsp_err_o, rsp_len_o);
      end else begin
        r = exp_rsp.pop_front();
        chk("rsp_err", rsp_err_o, r.err);
        chk("rsp_len", rsp_len_o, r.len);
        chk("rsp_data", rsp_data_o, r.data);
      end
    end
  end

  task automatic txn(logic [7:0] code, logic dbv, logic [7:0] db, logic [6:0] addr, logic rnw,
                     logic [2:0] len, logic [31:0] data, bit wait_done);
    int start;
    start = rsp_seen;
    @(negedge clk_i);
    req_code_i = code; req_db_valid_i = dbv; req_db_i = db; req_addr_i = addr;
    req_rnw_i = rnw; req_len_i = len; req_data_i = data; req_valid_i = 1'b1;
    @(negedge clk_i);
    // a second request while busy must be ignored entirely
    req_code_i = 8'hFF; req_db_valid_i = 1'b1; req_db_i = 8'hEE; req_addr_i = 7'h7F;
    req_rnw_i = ~rnw; req_len_i = 3'd4; req_data_i = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk_i);
    req_valid_i = 1'b0;
    if (wait_done) begin
      for (int i = 0; i < 400 && rsp_seen == start; i++) @(negedge clk_i);
      chk("rsp_arrived", rsp_seen != start, 1);
    end
  endtask

  initial begin
    bit found;
    req_valid_i = 0; req_code_i = 0; req_db_valid_i = 0; req_db_i = 0;
    req_addr_i = 0; req_rnw_i = 0; req_len_i = 0; req_data_i = 0;
    repeat (2) @(negedge clk_i);
    chk("rst_ready", req_ready_o, 1);
    chk("rst_bus_req", bus_req_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_bus_op", bus_op_o, 0);
    chk("rst_bus_byte", bus_byte_o, 0);
    chk("rst_rsp_err", rsp_err_o, 0);
    chk("rst_rsp_len", rsp_len_o, 0);
    chk("rst_rsp_data", rsp_data_o, 0);
    rst_ni = 1'b1;

    // ENEC broadcast, one data byte
    ex(OP_START); ex(OP_WRITE, 8'hFC); ex(OP_WRITE, 8'h00); ex(OP_WRITE, 8'h01); ex(OP_STOP);
    er(ERR_NONE, 0, 0);
    txn(8'h00, 0, 8'h00, 7'h00, 0, 3'd1, 32'h01, 1);

    // GETMRL direct read of two bytes
    rd_q.push_back(8'h12); rd_q.push_back(8'h34);
    ex(OP_START); ex(OP_WRITE, 8'hFC); ex(OP_WRITE, 8'h8C); ex(OP_RSTART); ex(OP_WRITE, 8'h15);
    ex(OP_READ, 8'h00, 0); ex(OP_READ, 8'h00, 1); ex(OP_STOP);
    er(ERR_NONE, 2, 32'h3412);
    txn(8'h8C, 0, 8'h00, 7'h0A, 1, 3'd2, 32'h0, 1);

    // RSTACT broadcast with defining byte, no data
    ex(OP_START); ex(OP_WRITE, 8'hFC); ex(OP_WRITE, 8'h2A); ex(OP_WRITE, 8'h01); ex(OP_STOP);
    er(ERR_NONE, 0, 0);
    txn(8'h2A, 1, 8'h01, 7'h00, 0, 3'd0, 32'h0, 1);

    // broadcast address NACK
    nack_en = 1; nack_byte = 8'hFC;
    ex(OP_START); ex(OP_WRITE, 8'hFC); ex(OP_STOP);
    er(ERR_NACK_BCAST, 0, 0);
    txn(8'h00, 0, 8'h00, 7'h00, 0, 3'd1, 32'h01, 1);

    // direct address NACK on SETMWL
    nack_byte = 8'h14;
    ex(OP_START); ex(OP_WRITE, 8'hFC); ex(OP_WRITE, 8'h89); ex(OP_RSTART); ex(OP_WRITE, 8'h14); ex(OP_STOP);
    er(ERR_NACK_ADDR, 0, 0);
    txn(8'h89, 0, 8'h00, 7'h0A, 0, 3'd2, 32'h4000, 1);

    // oversized length clamps to 4; NACK on a data byte has no effect
    nack_byte = 8'hBB;
    ex(OP_START); ex(OP_WRITE, 8'hFC); ex(OP_WRITE, 8'h01);
    ex(OP_WRITE, 8'hAA); ex(OP_WRITE, 8'hBB); ex(OP_WRITE, 8'hCC); ex(OP_WRITE, 8'hDD); ex(OP_STOP);
    er(ERR_NONE, 0, 0);
    txn(8'h01, 0, 8'h00, 7'h00, 0, 3'd7, 32'hDDCC_BBAA, 1);
    nack_en = 0;

    // SETMWL direct write
    ex(OP_START); ex(OP_WRITE, 8'hFC); ex(OP_WRITE, 8'h89); ex(OP_RSTART); ex(OP_WRITE, 8'h14);
    ex(OP_WRITE, 8'h00); ex(OP_WRITE, 8'h40); ex(OP_STOP);
    er(ERR_NONE, 0, 0);
    txn(8'h89, 0, 8'h00, 7'h0A, 0, 3'd2, 32'h4000, 1);

    // direct zero-length probe
    ex(OP_START); ex(OP_WRITE, 8'hFC); ex(OP_WRITE, 8'h8B); ex(OP_RSTART); ex(OP_WRITE, 8'h17); ex(OP_STOP);
    er(ERR_NONE, 0, 0);
    txn(8'h8B, 0, 8'h00, 7'h0B, 1, 3'd0, 32'h0, 1);

    // direct read with defining byte, three bytes
    rd_q.push_back(8'hA1); rd_q.push_back(8'hB2); rd_q.push_back(8'hC3);
    ex(OP_START); ex(OP_WRITE, 8'hFC); ex(OP_WRITE, 8'h8D); ex(OP_WRITE, 8'h05); ex(OP_RSTART);
    ex(OP_WRITE, 8'h15); ex(OP_READ, 8'h00, 0); ex(OP_READ, 8'h00, 0); ex(OP_READ, 8'h00, 1); ex(OP_STOP);
    er(ERR_NONE, 3, 32'h00C3_B2A1);
    txn(8'h8D, 1, 8'h05, 7'h0A, 1, 3'd3, 32'h0, 1);

    // reset while reading
    rd_q.push_back(8'h55); rd_q.push_back(8'h66);
    ex(OP_START); ex(OP_WRITE, 8'hFC); ex(OP_WRITE, 8'h8C); ex(OP_RSTART); ex(OP_WRITE, 8'h15);
    ex(OP_READ, 8'h00, 0);
    txn(8'h8C, 0, 8'h00, 7'h0A, 1, 3'd2, 32'h0, 0);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk_i);
      found = bus_req_o && bus_op_o == OP_READ;
    end
    chk("reached_read", found, 1);
    rst_ni = 1'b0;
    #1;
    chk("arst_bus_req", bus_req_o, 0);
    chk("arst_ready", req_ready_o, 1);
    chk("arst_rsp_valid", rsp_valid_o, 0);
    repeat (3) @(negedge clk_i);
    exp_ops.delete(); exp_rsp.delete(); rd_q.delete();
    rst_ni = 1'b1;
    chk("arst_rsp_len", rsp_len_o, 0);
    chk("arst_rsp_data", rsp_data_o, 0);
    rd_q.push_back(8'h77);
    ex(OP_START); ex(OP_WRITE, 8'hFC); ex(OP_WRITE, 8'h8C); ex(OP_RSTART); ex(OP_WRITE, 8'h15);
    ex(OP_READ, 8'h00, 1); ex(OP_STOP);
    er(ERR_NONE, 1, 32'h77);
    txn(8'h8C, 0, 8'h00, 7'h0A, 1, 3'd1, 32'h0, 1);

    repeat (4) @(negedge clk_i);
    chk("ops_drained", exp_ops.size(), 0);
    chk("rsp_drained", exp_rsp.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
